// File: rtl/lsu_bus_master_pkg.sv
// lsu_bus_master_pkg: op_type encodings, FSM states and address-range default
// for the MEM-stage load/store bus master.
`default_nettype none

package lsu_bus_master_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [31:0] ADDR_MAX_DEF = 32'h0000_3FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_bus_master_if.sv
// lsu_bus_master_if: byte-enabled req/ack data-memory bus between the LSU
// (master) and the data memory (slave).
`default_nettype none

interface lsu_bus_master_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-enable / store-replication generator and
// load-lane extractor with sign or zero extension.
`default_nettype none

module lsu_lane_align
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] st_rep,
  input  logic [2:0]  ld_op,
  input  logic [3:0]  ld_be,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    be     = 4'b0001 << st_off;
    st_rep = {4{st_data[7:0]}};
    if (is_word(st_op)) begin
      be     = 4'b1111;
      st_rep = st_data;
    end else if (is_half(st_op)) begin
      be     = st_off[1] ? 4'b1100 : 4'b0011;
      st_rep = {2{st_data[15:0]}};
    end
  end

  // The lane is chosen from the enables the bus actually carried.
  always_comb begin
    case (ld_be)
      4'b0010: w_byte = ld_word[15:8];
      4'b0100: w_byte = ld_word[23:16];
      4'b1000: w_byte = ld_word[31:24];
      default: w_byte = ld_word[7:0];
    endcase
    w_half = ld_be[2] ? ld_word[31:16] : ld_word[15:0];
    case (ld_op)
      OP_LB:   ld_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  ld_data = {24'h0, w_byte};
      OP_LH:   ld_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  ld_data = {16'h0, w_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: MEM-stage load/store initiator on a req/ack byte-enabled bus.
// Optional MISALIGN_EXC_EN: misaligned word/half accesses raise address exceptions.
`default_nettype none

module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter logic [31:0] ADDR_MAX = ADDR_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  lsu_bus_master_if.master bus
);

  state_t      r_state, w_state_nx;
  logic        w_req;
  logic        w_accept;
  logic        w_misalign;
  logic        w_illegal;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_rep;
  logic [31:0] w_ld_data;
  logic [2:0]  r_op;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

`ifdef MISALIGN_EXC_EN
  assign w_misalign = (is_word(op_type) && (addr[1:0] != 2'b00)) ||
                      (is_half(op_type) && addr[0]);
  assign w_off      = addr[1:0];
`else
  // Misaligned accesses are silently realigned down to their natural boundary.
  assign w_misalign = 1'b0;
  assign w_off      = is_word(op_type) ? 2'b00 :
                      is_half(op_type) ? {addr[1], 1'b0} : addr[1:0];
`endif

  assign w_illegal = (addr > ADDR_MAX) || w_misalign;
  assign w_accept  = (r_state == IDLE) && op_valid;

  lsu_lane_align u_align (
    .st_op   (op_type),
    .st_off  (w_off),
    .st_data (wdata),
    .be      (w_be),
    .st_rep  (w_rep),
    .ld_op   (r_op),
    .ld_be   (r_be),
    .ld_word (bus.mem_rdata),
    .ld_data (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    stall      = 1'b0;
    done       = 1'b0;
    w_req      = 1'b0;
    case (r_state)
      IDLE: begin
        if (op_valid) begin
          stall      = 1'b1;
          w_state_nx = w_illegal ? RESP : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        w_req = 1'b1;
        if (bus.mem_ack) w_state_nx = RESP;
      end
      RESP: begin
        done       = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.mem_req   = w_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_LW;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_be     <= 4'h0;
      r_wdata  <= 32'h0;
      rdata    <= 32'h0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
    end else if (w_accept) begin
      exc_adel <= w_illegal && !is_store(op_type);
      exc_ades <= w_illegal && is_store(op_type);
      if (!w_illegal) begin
        r_op    <= op_type;
        r_we    <= is_store(op_type);
        r_addr  <= {addr[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_rep;
      end
    end else if ((r_state == BUSY) && bus.mem_ack && !r_we) begin
      rdata <= w_ld_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed and randomized load/store sequences checked
// against an arithmetic reference model of the LSU bus master.
`default_nettype none

module tb_lsu_bus_master;
  import lsu_bus_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        exc_adel;
  logic        exc_ades;

  lsu_bus_master_if bus_if ();

  lsu_bus_master dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_type  (op_type),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .done     (done),
    .rdata    (rdata),
    .exc_adel (exc_adel),
    .exc_ades (exc_ades),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rdata = 32'h0;

  function automatic int m_size(input logic [2:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic bit m_store(input logic [2:0] op);
    return op >= OP_SW;
  endfunction

  function automatic bit m_exc(input logic [2:0] op, input logic [31:0] a);
    bit mis;
    mis = (a % m_size(op)) != 0;
`ifdef MISALIGN_EXC_EN
    return (a > 32'h3FFF) || mis;
`else
    return (a > 32'h3FFF) && (mis || !mis);
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input int off,
                                         input logic [31:0] rw);
    logic [31:0] v;
    v = rw >> (8 * off);
    case (op)
      OP_LB:  begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      OP_LBU: v = v & 32'hFF;
      OP_LH:  begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      OP_LHU: v = v & 32'hFFFF;
      default: v = rw;
    endcase
    return v;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int delay, input logic [31:0] rw, input string tag);
    int          sz, off;
    logic [31:0] ea, e_wd;
    logic [3:0]  e_be;
    bit          ex, st;
    sz   = m_size(op);
    st   = m_store(op);
    ex   = m_exc(op, a);
    ea   = a - (a % sz);
    off  = int'(ea % 4);
    e_be = 4'(((1 << sz) - 1) << off);
    e_wd = (sz == 4) ? wd : (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001
                                      : (wd & 32'hFF) * 32'h0101_0101;

    op_valid = 1'b1; op_type = op; addr = a; wdata = wd;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL %s accept_stall: got %b want 1", tag, stall);
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op_type = 3'($urandom_range(0, 7));
    addr = $urandom; wdata = $urandom;
    #1;

    if (!ex) begin
      for (int k = 0; k <= delay; k++) begin
        total++;
        if ({bus_if.mem_req, stall, done} !== 3'b110) begin
          bad++; $display("FAIL %s busy_ctl[%0d]: req/stall/done=%b want 110", tag, k,
                          {bus_if.mem_req, stall, done});
        end
        total++;
        if ({bus_if.mem_we, bus_if.mem_addr, bus_if.mem_be, bus_if.mem_wdata} !==
            {st, {ea[31:2], 2'b00}, e_be, e_wd}) begin
          bad++; $display("FAIL %s bus[%0d]: we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                          tag, k, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_be,
                          bus_if.mem_wdata, st, {ea[31:2], 2'b00}, e_be, e_wd);
        end
        bus_if.mem_ack   = (k == delay);
        bus_if.mem_rdata = (k == delay) ? rw : $urandom;
        @(posedge clk); #1;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = $urandom;
        #1;
      end
      if (!st) exp_rdata = m_load(op, off, rw);
    end

    total++;
    if ({done, bus_if.mem_req, stall, exc_adel, exc_ades} !== {3'b100, ex && !st, ex && st}) begin
      bad++; $display("FAIL %s resp: done/req/stall/adel/ades=%b want %b", tag,
                      {done, bus_if.mem_req, stall, exc_adel, exc_ades},
                      {3'b100, ex && !st, ex && st});
    end
    total++;
    if (rdata !== exp_rdata) begin
      bad++; $display("FAIL %s rdata: got %h want %h", tag, rdata, exp_rdata);
    end

    op_valid = 1'($urandom_range(0, 1)); op_type = 3'($urandom_range(0, 7));
    addr = 32'($urandom_range(0, 32'h3FFF)) & 32'hFFFF_FFFC;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL %s resp_stall: got %b want 0", tag, stall);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    total++;
    if ({done, bus_if.mem_req, stall} !== 3'b000 || rdata !== exp_rdata) begin
      bad++; $display("FAIL %s after: done/req/stall=%b rdata=%h want 000 rdata=%h", tag,
                      {done, bus_if.mem_req, stall}, rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op_type = OP_LW; addr = 32'h0; wdata = 32'h0;
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus_if.mem_req, bus_if.mem_we, done, exc_adel, exc_ades, stall} !== 6'b0 ||
        bus_if.mem_addr !== 32'h0 || bus_if.mem_be !== 4'h0 ||
        bus_if.mem_wdata !== 32'h0 || rdata !== 32'h0) begin
      bad++; $display("FAIL reset: ctl=%b addr=%h be=%b wd=%h rdata=%h want all 0",
                      {bus_if.mem_req, bus_if.mem_we, done, exc_adel, exc_ades, stall},
                      bus_if.mem_addr, bus_if.mem_be, bus_if.mem_wdata, rdata);
    end
    rst = 1'b0;
    exp_rdata = 32'h0;
    @(posedge clk); #2;
  endtask

  task automatic test_plan();
    do_op(OP_SW,  32'h10,   32'hDEAD_BEEF, 0, 32'h0,         "sw_0x10");
    do_op(OP_SB,  32'h13,   32'h0000_00A5, 1, 32'h0,         "sb_0x13");
    do_op(OP_LB,  32'h12,   32'h0,         0, 32'h1280_5634, "lb_0x12");
    do_op(OP_SH,  32'h22,   32'h1234_CAFE, 0, 32'h0,         "sh_0x22");
    do_op(OP_LBU, 32'h12,   32'h0,         0, 32'h1280_5634, "lbu_0x12");
    do_op(OP_LH,  32'h2,    32'h0,         3, 32'h9ABC_0000, "lh_0x2");
    do_op(OP_LHU, 32'h0,    32'h0,         1, 32'h1234_8765, "lhu_0x0");
    do_op(OP_LW,  32'h6,    32'h0,         0, 32'h5566_7788, "lw_0x6");
    do_op(OP_SH,  32'h1,    32'h0000_BEEF, 0, 32'h0,         "sh_0x1");
    do_op(OP_SW,  32'h4000, 32'h1111_2222, 0, 32'h0,         "sw_0x4000");
    do_op(OP_LBU, 32'h3FFF, 32'h0,         2, 32'hC300_0000, "lbu_0x3fff");
    do_op(OP_LB,  32'h4000, 32'h0,         0, 32'hFFFF_FFFF, "lb_0x4000");
  endtask

  task automatic test_ack_idle();
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      total++;
      if ({done, bus_if.mem_req, stall} !== 3'b000 || rdata !== exp_rdata) begin
        bad++; $display("FAIL ack_idle[%0d]: done/req/stall=%b rdata=%h want 000 rdata=%h",
                        k, {done, bus_if.mem_req, stall}, rdata, exp_rdata);
      end
    end
    bus_if.mem_ack = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    op_valid = 1'b1; op_type = OP_LW; addr = 32'h20; wdata = 32'h0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    total++;
    if (bus_if.mem_req !== 1'b1) begin
      bad++; $display("FAIL rst_mid busy_req: got %b want 1", bus_if.mem_req);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus_if.mem_req, stall, done} !== 3'b000) begin
      bad++; $display("FAIL rst_mid drop: req/stall/done=%b want 000", {bus_if.mem_req, stall, done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = 32'h0;
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h8765_4321;
    @(posedge clk); #1;
    bus_if.mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if ({done, bus_if.mem_req, stall} !== 3'b000 || rdata !== 32'h0) begin
        bad++; $display("FAIL rst_mid late_ack[%0d]: done/req/stall=%b rdata=%h want 000 rdata=0",
                        k, {done, bus_if.mem_req, stall}, rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 32'h4000 + 32'($urandom_range(0, 32'hFFFF));
      else                           a = 32'($urandom_range(0, 32'h3FFF));
      do_op(op, a, $urandom, $urandom_range(0, 3), $urandom, $sformatf("rnd%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_ack_idle();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      do_op(OP_LW, 32'(n * 4), 32'h0, 0, 32'h0101_0101 * 32'(n + 1), $sformatf("b2b%0d", n));
    end
  endtask

endmodule

`default_nettype wire

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store initiator for the MEM stage: takes one load or store per instruction from the pipeline and drives a byte-enabled, req/ack-handshaked data-memory bus. It generates the byte enables and replicated store data, waits for the memory acknowledge, and returns sign- or zero-extended load data. It stalls the pipeline for the length of each access and flags address exceptions. It is the requesting end of the data-memory port, facing the byte-enabled data memory.

## Interface
- ADDR_MAX, 32'h0000_3FFF, highest legal byte address (4096 words); any access above it raises an address exception.
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  MEM-stage instruction is a load or store.
- op_type  in  3  LW, LH, LHU, LB, LBU, SW, SH, SB (encodings in the shared header).
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- stall  out  1  freeze the pipeline this cycle.
- done  out  1  one-cycle pulse: access complete; rdata/exc valid.
- rdata  out  32  extended load result, held until the next done.
- exc_adel  out  1  load address error, valid with done.
- exc_ades  out  1  store address error, valid with done.
- mem_req  out  1  bus request.
- mem_we  out  1  write (1) / read (0).
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completed the request (same-cycle ack allowed).
- mem_rdata  in  32  full read word, valid with mem_ack.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: op_valid=1 accepts the op. Legal op: latch the bus fields and go to BUSY. Illegal op: latch exc_adel (load) or exc_ades (store) and go to RESP with no bus request.
- BUSY: mem_req=1 with all mem_* outputs stable. Posedge with mem_ack=1: capture and extend mem_rdata into rdata (loads only; stores leave rdata unchanged), then go to RESP.
- RESP: done=1 for exactly one cycle, then unconditionally go to IDLE. op_valid in RESP belongs to the retiring instruction and is ignored.
- Byte enables:
  - SW/LW: 1111.
  - SH/LH/LHU: addr[1] ? 1100 : 0011.
  - SB/LB/LBU: 0001 << addr[1:0].
- Store data: SW passes wdata; SH drives {2{wdata[15:0]}}; SB drives {4{wdata[7:0]}}.
- Load extraction selects the lane(s) named by mem_be. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Exception conditions:
  - addr > ADDR_MAX: always an exception.
  - Misalignment (see Configuration): word op with addr[1:0]!=0, or half op with addr[0]=1.
- Exception flags are cleared on the next accepted op.

## Timing
- stall = (IDLE & op_valid) | BUSY. stall is 0 in RESP.
- Legal access: accept in cycle 0, mem_req in cycle 1. If ack arrives in cycle 1, done is in cycle 2, for a minimum of 2 stall cycles. Each extra cycle without ack adds one stall cycle.
- Exception access: done in cycle 1, after one stall cycle.
- mem_ack outside BUSY is ignored.
- Reset values: state IDLE; mem_req, mem_we, done, exc_adel, exc_ades = 0; mem_addr, mem_be, mem_wdata, rdata = 0.
- Reset mid-access drops mem_req immediately (asynchronous). A late mem_ack after reset is ignored.

## Configuration
- MISALIGN_EXC_EN defined:
  - Misaligned word/half accesses raise exc_adel/exc_ades.
  - No bus request is issued for them.
- MISALIGN_EXC_EN undefined:
  - Misalignment is never an exception.
  - Word ops force addr[1:0]=0; half ops force addr[0]=0.
  - The access then proceeds normally.
  - The range check is unaffected.

## Structure
- Shared constants header holds the op_type encodings, the FSM state encodings and the ADDR_MAX default.
- One combinational sub-module, lsu_lane_align, computes:
  - mem_be and replicated store data from op_type/addr;
  - the extended load result from op_type, be and the read word.
- The FSM and registers stay in lsu_bus_master.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF, ack in cycle 1 -> mem_be=1111, mem_wdata=0xDEADBEEF, 2 stall cycles, done in cycle 2.
- SB addr 0x13, wdata 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x10.
- LB addr 0x12, mem_rdata 0x12805634 -> rdata=0xFFFFFF80. LBU same stimulus -> rdata=0x00000080.
- LH addr 0x2, ack delayed 3 cycles, mem_rdata 0x9ABC0000 -> mem_req held 4 cycles with constant outputs, rdata=0xFFFF9ABC.
- LW addr 0x6 with MISALIGN_EXC_EN -> no mem_req, done+exc_adel in cycle 1. Without the macro -> mem_addr=0x4, normal load. SW addr 0x4000 -> exc_ades in both builds.
- rst asserted while BUSY -> mem_req=0 in the same cycle, state IDLE; a following mem_ack produces no done.
